// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU execution sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_PAUSE = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } run_state_t;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_RUN  = 2'b10;
  localparam logic [1:0] MODE_SLOW = 2'b11;

  // Both continuous-run modes share the upper mode bit.
  function automatic logic mode_is_running(input logic [1:0] m);
    return m[1];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability down-counter and
// press-edge detector. The button is active-low; only a press (debounced
// high->low transition) produces a one-cycle pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK_50,
  input  logic reset,
  input  logic btn_n,
  output logic press_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;
  logic          w_differs;
  logic          w_commit;

  // A sample that disagrees with the debounced level counts down; the level
  // only moves once DEBOUNCE_CYCLES consecutive samples have disagreed.
  assign w_differs = (r_sync1 != r_level);
  assign w_commit  = w_differs && (r_cnt == '0);

  // Bring the raw button into the clock domain (released = 1 after reset).
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
    end else begin
      r_sync0 <= btn_n;
      r_sync1 <= r_sync0;
    end
  end

  // Stability timer: reload whenever the input agrees or a change commits.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_cnt <= RELOAD;
    end else if (!w_differs || w_commit) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Debounced level and the registered press pulse.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_level <= 1'b1;
      r_pulse <= 1'b0;
    end else begin
      if (w_commit) begin
        r_level <= r_sync1;
      end
      r_pulse <= w_commit && !r_sync1;
    end
  end

  assign press_pulse = r_pulse;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution sequencer for the CPU: reset hold, pause, run, slow-run,
// single-step and halt at the final PC, plus an exact enable counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RESET | cpu_rst held high for RESET_HOLD cycles, counter cleared
// S_PAUSE | idle; runs on mode RUN/SLOW, single-steps on step press
// S_RUN   | enables every cycle (RUN) or once per divider wrap (SLOW)
// S_DONE  | pc reached FINAL_PC; enables blocked, count frozen
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_WIDTH        = 12,
  parameter int FINAL_PC        = 86,
  parameter int RESET_HOLD      = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SLOW_DIV_LOG2   = 22,
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                   CLK_50,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   btn_step_n,
  input  logic                   restart,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic                   cpu_en,
  output logic                   cpu_rst,
  output logic                   done,
  output logic [1:0]             state,
  output logic [COUNT_WIDTH-1:0] exec_count
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  run_state_t               r_state;
  run_state_t               w_next_state;
  logic [HOLD_W-1:0]        r_hold;
  logic [SLOW_DIV_LOG2-1:0] r_div;
  logic [COUNT_WIDTH-1:0]   r_count;
  logic                     r_done;
  logic                     w_cpu_en;
  logic                     w_step_pulse;
  logic                     w_at_final;
  logic                     w_slow_tick;
  logic                     w_hold_done;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .CLK_50      (CLK_50),
    .reset       (reset),
    .btn_n       (btn_step_n),
    .press_pulse (w_step_pulse)
  );

  assign w_at_final  = (pc == PC_WIDTH'(FINAL_PC));
  assign w_slow_tick = &r_div;
  assign w_hold_done = (r_hold == HOLD_W'(RESET_HOLD - 1));

  // State register.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and per-cycle CPU enable; restart overrides everything.
  // The final-PC check also gates the enable so the instruction at
  // FINAL_PC is never executed.
  always_comb begin
    w_next_state = r_state;
    w_cpu_en     = 1'b0;
    case (r_state)
      S_RESET: begin
        if (w_hold_done) begin
          w_next_state = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (mode_is_running(mode)) begin
          w_next_state = S_RUN;
        end else if ((mode == MODE_STEP) && w_step_pulse) begin
          if (w_at_final) begin
            w_next_state = S_DONE;
          end else begin
            w_cpu_en = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_at_final) begin
          w_next_state = S_DONE;
        end else if (!mode_is_running(mode)) begin
          w_next_state = S_PAUSE;
        end else if (mode == MODE_RUN) begin
          w_cpu_en = 1'b1;
        end else begin
          w_cpu_en = w_slow_tick;
        end
      end
      S_DONE: begin
        w_next_state = S_DONE;
      end
      default: begin
        w_next_state = S_RESET;
      end
    endcase
    if (restart) begin
      w_next_state = S_RESET;
      w_cpu_en     = 1'b0;
    end
  end

  // Reset hold counter: counts only while staying in S_RESET, so a
  // restart issued during S_RESET restarts the full hold period.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
    end else if ((r_state == S_RESET) && (w_next_state == S_RESET) && !restart) begin
      r_hold <= r_hold + HOLD_W'(1);
    end else begin
      r_hold <= '0;
    end
  end

  // Slow-run divider: free-runs in S_RUN, held at zero elsewhere so every
  // run entry starts a fresh period.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (r_state == S_RUN) begin
      r_div <= r_div + SLOW_DIV_LOG2'(1);
    end else begin
      r_div <= '0;
    end
  end

  // Enable counter: cleared while entering or sitting in S_RESET so it
  // already reads zero on the first reset cycle; saturates at all-ones.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if ((r_state == S_RESET) || (w_next_state == S_RESET)) begin
      r_count <= '0;
    end else if (w_cpu_en && !(&r_count)) begin
      r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  // Registered done flag, high from the first S_DONE cycle.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (w_next_state == S_DONE);
    end
  end

  assign cpu_en     = w_cpu_en;
  assign cpu_rst    = (r_state == S_RESET);
  assign done       = r_done;
  assign state      = r_state;
  assign exec_count = r_count;

endmodule
